// File: rtl/gate_truth_checker_if.sv
// Bundle between the truth checker and its environment: run control,
// gate-under-test stimulus/response and the result outputs.
//   start            : run request (environment -> checker)
//   a, b             : stimulus to the gate under test (checker -> gate)
//   y                : gate-under-test response (gate -> checker)
//   busy, done       : run status (checker -> environment)
//   pass, err_count,
//   first_fail_*     : results of the last completed run (checker -> environment)
interface gate_truth_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       first_fail_valid;
    logic [1:0] first_fail_idx;

    // Checker side
    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_count, first_fail_valid, first_fail_idx
    );

    // Environment side
    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/gate_truth_checker.sv
// On-chip response checker for a 2-input gate. A start pulse walks the four
// input vectors (a = idx[1], b = idx[0]), holds each SETTLE_CYCLES cycles,
// samples y one cycle later and compares it against EXPECTED[idx].
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : gate_truth_checker_if.master (start/y in; a, b, busy, done,
//                pass, err_count, first_fail_valid, first_fail_idx out)
module gate_truth_checker #(
    parameter logic [3:0]  EXPECTED      = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_truth_checker_if.master  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_a, w_a_nxt;
    logic             r_b, w_b_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic [2:0]       r_err, w_err_nxt;
    logic             r_ffv, w_ffv_nxt;
    logic [1:0]       r_ffi, w_ffi_nxt;
    logic             w_mism;

    assign w_mism = (bus.y != EXPECTED[r_idx]);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_ffv   <= 1'b0;
            r_ffi   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_ffv   <= w_ffv_nxt;
            r_ffi   <= w_ffi_nxt;
        end
    end

    // Next state; output next-values reflect the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = 1'b0;
        w_b_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_ffv_nxt   = r_ffv;
        w_ffi_nxt   = r_ffi;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_DRIVE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = 3'd0;
                    w_ffv_nxt   = 1'b0;
                    w_ffi_nxt   = 2'd0;
                end
            end

            ST_DRIVE: begin
                w_busy_nxt = 1'b1;
                w_a_nxt    = r_idx[1];
                w_b_nxt    = r_idx[0];
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (w_mism) begin
                    w_err_nxt = r_err + 3'd1;
                    if (!r_ffv) begin
                        w_ffv_nxt = 1'b1;
                        w_ffi_nxt = r_idx;
                    end
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    // Includes the vector-3 result just folded into w_err_nxt
                    w_pass_nxt  = (w_err_nxt == 3'd0);
                end else begin
                    w_state_nxt = ST_DRIVE;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_a_nxt     = w_idx_nxt[1];
                    w_b_nxt     = w_idx_nxt[0];
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.a                = r_a;
    assign bus.b                = r_b;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.err_count        = r_err;
    assign bus.first_fail_valid = r_ffv;
    assign bus.first_fail_idx   = r_ffi;

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking hardware harness for 2-input combinational gates. On a start pulse it drives all four input combinations onto a gate under test and waits a programmable settle time for each. It then samples the gate output and compares it against a parameterised truth table. It reports pass/fail, the error count and the first failing vector. It is the on-chip response-checking counterpart to stimulus-only gate benches, used in the common-cell regression and in silicon bring-up of the basic gate library.

## Interface
- EXPECTED, 4'b1000, expected truth table; bit k = expected y for vector k, where vector k drives a = k[1], b = k[0] (default = AND)
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..255
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled at rising edge; honoured only in IDLE
- a  out  1  stimulus to gate under test
- b  out  1  stimulus to gate under test
- y  in  1  gate-under-test response
- busy  out  1  high while vectors are being applied (DRIVE/SAMPLE)
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  1 when the last completed run had zero mismatches
- err_count  out  3  mismatches in the last run, 0..4
- first_fail_valid  out  1  at least one mismatch in the last run
- first_fail_idx  out  2  vector index of the first mismatch; 0 when not valid

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a = b = 0, busy = 0.
  - start = 1 → DRIVE, with idx = 0, settle counter = 0, err_count = 0, first_fail_valid = 0, first_fail_idx = 0, pass = 0.
- DRIVE:
  - a = idx[1], b = idx[0].
  - The settle counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - a and b are still held.
  - At the closing edge, y is compared with EXPECTED[idx].
  - On mismatch: err_count += 1. If first_fail_valid = 0, first_fail_idx = idx and first_fail_valid = 1.
  - If idx = 3 → DONE. Otherwise idx += 1, the counter clears, → DRIVE.
- DONE:
  - done = 1 for exactly this one cycle.
  - pass is registered as (err_count final == 0) on entry to DONE, i.e. it already includes the vector-3 result.
  - a = b = 0.
  - → IDLE unconditionally.
- Result outputs (pass, err_count, first_fail_*) hold their values from DONE until the next accepted start.
- start asserted in DRIVE, SAMPLE or DONE is ignored; it is not queued.
- err_count is 3 bits wide and saturation is unnecessary (max 4).
- y is treated as synchronous to clk; no synchroniser is provided.

## Timing
- Reset (rst_n = 0, immediate, any state): state = IDLE, a = 0, b = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail_valid = 0, first_fail_idx = 0.
- Reset mid-run aborts the run; no done pulse is emitted.
- Let E0 be the edge at which start is accepted, and P = SETTLE_CYCLES + 1.
- Vector k is driven from E0 + k·P until E0 + (k+1)·P. y for vector k is sampled at edge E0 + (k+1)·P.
- busy is high from after E0 until after E0 + 4P.
- done is high between E0 + 4P and E0 + 4P + 1. The earliest next start is accepted at E0 + 4P + 1.
- With default SETTLE_CYCLES = 1, vectors change every 2 cycles and done rises 8 cycles after start is accepted.
- Results update on sample edges during the run. They are final and stable from the DONE cycle onward.

## Test plan
- Default params, y = a & b, one start pulse:
  - a/b sequence 00, 01, 10, 11, 2 cycles each.
  - done 8 cycles after start.
  - pass = 1, err_count = 0, first_fail_valid = 0.
- y stuck at 0:
  - err_count = 1, first_fail_idx = 3, first_fail_valid = 1, pass = 0.
- y stuck at 1:
  - err_count = 3, first_fail_idx = 0, pass = 0.
- y = ~(a & b):
  - err_count = 4, first_fail_idx = 0, pass = 0.
- Same run with EXPECTED = 4'b0111 (NAND):
  - pass = 1, err_count = 0.
- SETTLE_CYCLES = 3, y = a & b:
  - each vector held 4 cycles, done 16 cycles after start.
- start re-pulsed at cycles 3 and 5 of a run → ignored, a single done at cycle 8.
- Reset mid-run: rst_n low at cycle 5 of a run with y stuck at 0 →
  - all outputs return to their reset values immediately, and no done pulse follows.
  - A new start with y = a & b then gives pass = 1, err_count = 0.
